// File: rtl/pid_multichannel_if.sv
// Sample/result bus for the multichannel PID engine.
// Sink: a sample transfers on a clk edge where sink_data_valid && sink_ready; valid
// while ready is low is dropped, not held. Source: source_data_valid is a one-cycle strobe.
interface pid_multichannel_if #(
  parameter int CH_W   = 2,
  parameter int CMD_W  = 8,
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8,
  parameter int OUT_W  = 15
) ();
  logic                     sink_data_valid;
  logic                     sink_ready;
  logic [CH_W-1:0]          sink_channel;
  logic                     sink_clear;
  logic [CMD_W-1:0]         sink_command;
  logic [DATA_W-1:0]        sink_data;
  logic [GAIN_W-1:0]        sink_kp;
  logic [GAIN_W-1:0]        sink_ki;
  logic [GAIN_W-1:0]        sink_kd;
  logic                     source_data_valid;
  logic [CH_W-1:0]          source_channel;
  logic signed [OUT_W-1:0]  source_pid;

  modport master (
    output sink_data_valid, sink_channel, sink_clear, sink_command, sink_data,
           sink_kp, sink_ki, sink_kd,
    input  sink_ready, source_data_valid, source_channel, source_pid
  );

  modport slave (
    input  sink_data_valid, sink_channel, sink_clear, sink_command, sink_data,
           sink_kp, sink_ki, sink_kd,
    output sink_ready, source_data_valid, source_channel, source_pid
  );
endinterface

// File: rtl/pid_multichannel.sv
// Time-multiplexed PID engine: one shared multiplier serves N_CH loops, each with its
// own integrator (anti-windup clamped), previous error and first-sample flag.
module pid_multichannel #(
  parameter int N_CH       = 4,
  parameter int CH_W       = $clog2(N_CH),
  parameter int CMD_W      = 8,
  parameter int CMD_SHIFT  = 4,
  parameter int DATA_W     = 16,
  parameter int GAIN_W     = 8,
  parameter int INT_LIM    = 4096,
  parameter int FRAC_SHIFT = 4,
  parameter int OUT_W      = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  pid_multichannel_if.slave    bus,
  output logic [2:0]           o_dbg_state
);

  localparam int E_W   = DATA_W + 2;
  localparam int OPB_W = DATA_W + 3;
  localparam int ACC_W = GAIN_W + DATA_W + 4;
  localparam int INT_W = $clog2(INT_LIM) + 2;

  localparam logic signed [OPB_W-1:0] L_INT_POS = OPB_W'(INT_LIM);
  localparam logic signed [OPB_W-1:0] L_INT_NEG = -L_INT_POS;
  localparam logic signed [OUT_W-1:0] L_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] L_OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_PMUL, S_IMUL, S_DMUL, S_SUM, S_OUT
  } state_t;

  state_t                   r_state, w_state_next;
  logic [CH_W-1:0]          r_ch;
  logic                     r_clear;
  logic [CMD_W-1:0]         r_cmd;
  logic [DATA_W-1:0]        r_data;
  logic [GAIN_W-1:0]        r_kp, r_ki, r_kd;
  logic signed [E_W-1:0]    r_e;
  logic signed [ACC_W-1:0]  r_p, r_i, r_d;
  logic signed [INT_W-1:0]  r_integ [N_CH];
  logic signed [E_W-1:0]    r_prev  [N_CH];
  logic                     r_first [N_CH];
  logic signed [OUT_W-1:0]  r_src_pid;
  logic [CH_W-1:0]          r_src_ch;

  logic [E_W-1:0]           w_setpoint;
  logic signed [E_W-1:0]    w_e;
  logic signed [OPB_W-1:0]  w_isum;
  logic signed [INT_W-1:0]  w_integ_new;
  logic signed [OPB_W-1:0]  w_diff;
  logic [GAIN_W-1:0]        w_gain;
  logic signed [OPB_W-1:0]  w_opb;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [OUT_W-1:0]  w_sat;
  logic                     w_ready;
  logic                     w_out_valid;

  assign w_setpoint = {{(E_W-CMD_W-CMD_SHIFT){1'b0}}, r_cmd, {CMD_SHIFT{1'b0}}};
  assign w_e        = $signed(w_setpoint) - $signed({2'b00, r_data});
  assign w_isum     = OPB_W'(r_integ[r_ch]) + OPB_W'(r_e);
  assign w_diff     = OPB_W'(r_e) - OPB_W'(r_prev[r_ch]);

  always_comb begin
    w_integ_new = w_isum[INT_W-1:0];
    if (w_isum > L_INT_POS)      w_integ_new = INT_W'(L_INT_POS);
    else if (w_isum < L_INT_NEG) w_integ_new = INT_W'(L_INT_NEG);
  end

  // Single multiplier; gains are unsigned, so they enter with a zero sign bit.
  always_comb begin
    w_gain = r_kp;
    w_opb  = OPB_W'(r_e);
    case (r_state)
      S_IMUL: begin w_gain = r_ki; w_opb = OPB_W'(w_integ_new); end
      S_DMUL: begin w_gain = r_kd; w_opb = w_diff;               end
      default: ;
    endcase
  end
  assign w_prod = ACC_W'($signed({1'b0, w_gain})) * ACC_W'(w_opb);

  assign w_sum   = r_p + r_i + r_d;
  assign w_shift = w_sum >>> FRAC_SHIFT;

  always_comb begin
    w_sat = w_shift[OUT_W-1:0];
    if (w_shift > ACC_W'(L_OUT_MAX))      w_sat = L_OUT_MAX;
    else if (w_shift < ACC_W'(L_OUT_MIN)) w_sat = L_OUT_MIN;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.sink_data_valid) w_state_next = S_ERR;
      end
      S_ERR:  w_state_next = S_PMUL;
      S_PMUL: w_state_next = S_IMUL;
      S_IMUL: w_state_next = S_DMUL;
      S_DMUL: w_state_next = S_SUM;
      S_SUM:  w_state_next = S_OUT;
      S_OUT: begin
        w_out_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_clear   <= 1'b0;
      r_cmd     <= '0;
      r_data    <= '0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_kd      <= '0;
      r_e       <= '0;
      r_p       <= '0;
      r_i       <= '0;
      r_d       <= '0;
      r_src_pid <= '0;
      r_src_ch  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_integ[k] <= '0;
        r_prev[k]  <= '0;
        r_first[k] <= 1'b1;
      end
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: if (bus.sink_data_valid) begin
          r_ch    <= bus.sink_channel;
          r_clear <= bus.sink_clear;
          r_cmd   <= bus.sink_command;
          r_data  <= bus.sink_data;
          r_kp    <= bus.sink_kp;
          r_ki    <= bus.sink_ki;
          r_kd    <= bus.sink_kd;
        end
        S_ERR: begin
          r_e <= w_e;
          if (r_clear) begin
            r_integ[r_ch] <= '0;
            r_prev[r_ch]  <= '0;
            r_first[r_ch] <= 1'b1;
          end
        end
        S_PMUL: r_p <= w_prod;
        S_IMUL: begin
          r_i           <= w_prod;
          r_integ[r_ch] <= w_integ_new;
        end
        S_DMUL: begin
          // No history yet on a fresh or cleared channel, so the derivative term is zero.
          r_d           <= r_first[r_ch] ? '0 : w_prod;
          r_prev[r_ch]  <= r_e;
          r_first[r_ch] <= 1'b0;
        end
        S_SUM: begin
          r_src_pid <= w_sat;
          r_src_ch  <= r_ch;
        end
        default: ;
      endcase
    end
  end

  assign bus.sink_ready        = w_ready;
  assign bus.source_data_valid = w_out_valid;
  assign bus.source_pid        = r_src_pid;
  assign bus.source_channel    = r_src_ch;
  assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_pid_multichannel.sv
// Randomised and directed bench for pid_multichannel against an arithmetic PID model.
module tb_pid_multichannel;
  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int CMD_W  = 8;
  localparam int DATA_W = 16;
  localparam int GAIN_W = 8;
  localparam int OUT_W  = 15;
  localparam int EXP_W  = CH_W + OUT_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  pid_multichannel_if #(.CH_W(CH_W), .CMD_W(CMD_W), .DATA_W(DATA_W),
                        .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();

  pid_multichannel dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  longint m_integ [N_CH];
  longint m_prev  [N_CH];
  bit     m_first [N_CH];

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_integ[k] = 0;
      m_prev[k]  = 0;
      m_first[k] = 1'b1;
    end
  endfunction

  function automatic longint model(input int ch, input bit clr, input longint cmd,
                                   input longint data, input longint kp,
                                   input longint ki, input longint kd);
    longint e, p, i, d, s, r, integ_new;
    e = cmd * 16 - data;
    if (clr) begin
      m_integ[ch] = 0;
      m_prev[ch]  = 0;
      m_first[ch] = 1'b1;
    end
    p = kp * e;
    integ_new = m_integ[ch] + e;
    if (integ_new > 4096)  integ_new = 4096;
    if (integ_new < -4096) integ_new = -4096;
    m_integ[ch] = integ_new;
    i = ki * integ_new;
    d = m_first[ch] ? 0 : kd * (e - m_prev[ch]);
    m_prev[ch]  = e;
    m_first[ch] = 1'b0;
    s = p + i + d;
    r = s >>> 4;
    if (r > 16383)  r = 16383;
    if (r < -16384) r = -16384;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];

  always @(negedge clk) begin
    if (reset && bus.source_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        logic [EXP_W-1:0] e;
        logic [OUT_W-1:0] e_pid;
        logic [CH_W-1:0]  e_ch;
        int               a;
        e     = exp_q.pop_front();
        a     = acc_q.pop_front();
        e_pid = e[OUT_W-1:0];
        e_ch  = e[EXP_W-1:OUT_W];
        check("pid", longint'($signed(bus.source_pid)), longint'($signed(e_pid)));
        check("channel", longint'(bus.source_channel), longint'(e_ch));
        // capturing edge downstream is the next posedge
        check("latency", longint'(cyc + 1 - a), 6);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; presents one sample for one clock edge.
  task automatic offer(input logic [CH_W-1:0] ch, input bit clr, input int cmd,
                       input int data, input int kp, input int ki, input int kd,
                       output bit accepted);
    longint pid;
    bus.sink_channel    = ch;
    bus.sink_clear      = clr;
    bus.sink_command    = CMD_W'(cmd);
    bus.sink_data       = DATA_W'(data);
    bus.sink_kp         = GAIN_W'(kp);
    bus.sink_ki         = GAIN_W'(ki);
    bus.sink_kd         = GAIN_W'(kd);
    bus.sink_data_valid = 1'b1;
    accepted = bus.sink_ready;
    @(posedge clk);
    @(negedge clk);
    bus.sink_data_valid = 1'b0;
    bus.sink_command    = CMD_W'($urandom);
    bus.sink_data       = DATA_W'($urandom);
    if (accepted) begin
      pid = model(int'(ch), clr, cmd, data, kp, ki, kd);
      exp_q.push_back({ch, pid[OUT_W-1:0]});
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.sink_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("drain_timeout", longint'(exp_q.size()), 0);
    wait_ready();
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input bit clr, input int cmd,
                      input int data, input int kp, input int ki, input int kd);
    bit acc;
    wait_ready();
    offer(ch, clr, cmd, data, kp, ki, kd, acc);
    if (!acc) check("send_accept", 0, 1);
  endtask

  // Sends one sample and checks the held output against a literal value.
  task automatic send_expect(input string tag, input logic [CH_W-1:0] ch, input bit clr,
                             input int cmd, input int data, input int kp, input int ki,
                             input int kd, input int exp);
    send(ch, clr, cmd, data, kp, ki, kd);
    drain();
    check(tag, longint'($signed(bus.source_pid)), longint'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_acc;
    bit acc;
    bus.sink_data_valid = 1'b0;
    bus.sink_channel    = '0;
    bus.sink_clear      = 1'b0;
    bus.sink_command    = '0;
    bus.sink_data       = '0;
    bus.sink_kp         = '0;
    bus.sink_ki         = '0;
    bus.sink_kd         = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", longint'(bus.sink_ready), 1);
    check("rst_valid", longint'(bus.source_data_valid), 0);
    check("rst_pid", longint'($signed(bus.source_pid)), 0);
    check("rst_channel", longint'(bus.source_channel), 0);
    check("rst_state", longint'(dbg_state), 0);
    reset = 1'b1;
    @(negedge clk);

    // P only, offered every 4 cycles: every other offer lands while busy
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      offer(2'd0, 1'b0, 60, 1020, 100, 0, 0, acc);
      if (acc) n_acc++;
      repeat (3) @(negedge clk);
    end
    check("t1_accepted", longint'(n_acc), 3);
    drain();
    check("t1_pid_hold", longint'($signed(bus.source_pid)), -375);

    // I accumulation, then anti-windup
    send_expect("t2_i1", 2'd1, 1'b0, 60, 900, 0, 100, 0, 375);
    send_expect("t2_i2", 2'd1, 1'b0, 60, 900, 0, 100, 0, 750);
    send_expect("t2_i3", 2'd1, 1'b0, 60, 900, 0, 100, 0, 1125);
    send_expect("t2_clamp1", 2'd1, 1'b0, 255, 0, 0, 1, 0, 256);
    send_expect("t2_clamp2", 2'd1, 1'b0, 255, 0, 0, 1, 0, 256);

    // D term with first-sample rule
    send_expect("t3_d1", 2'd2, 1'b0, 60, 960, 0, 0, 16, 0);
    send_expect("t3_d2", 2'd2, 1'b0, 60, 1080, 0, 0, 16, -120);
    send_expect("t3_d3", 2'd2, 1'b0, 60, 1080, 0, 0, 16, 0);

    // Output saturation
    send_expect("t4_sat_pos", 2'd3, 1'b0, 255, 0, 255, 0, 0, 16383);
    send_expect("t4_sat_neg", 2'd3, 1'b0, 0, 65535, 255, 0, 0, -16384);

    // Channel independence and clear
    send_expect("t5_c0a", 2'd0, 1'b1, 60, 900, 0, 100, 0, 375);
    send_expect("t5_c1a", 2'd1, 1'b1, 60, 1020, 0, 100, 0, -375);
    send_expect("t5_c0b", 2'd0, 1'b0, 60, 900, 0, 100, 0, 750);
    send_expect("t5_c1b", 2'd1, 1'b0, 60, 1020, 0, 100, 0, -750);
    send_expect("t5_c0clr", 2'd0, 1'b1, 60, 900, 0, 100, 0, 375);
    send_expect("t5_c1c", 2'd1, 1'b0, 60, 1020, 0, 100, 0, -1125);

    // Reset during IMUL aborts the sample
    send(2'd1, 1'b0, 60, 900, 0, 100, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    model_reset();
    @(negedge clk);
    check("t6_valid", longint'(bus.source_data_valid), 0);
    check("t6_pid", longint'($signed(bus.source_pid)), 0);
    check("t6_channel", longint'(bus.source_channel), 0);
    check("t6_ready", longint'(bus.sink_ready), 1);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    send_expect("t6_after", 2'd1, 1'b0, 60, 900, 0, 100, 0, 375);

    // Randomised traffic with random gaps; offers during busy cycles are dropped
    for (int k = 0; k < 150; k++) begin
      int cmd, dv;
      cmd = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) dv = int'($urandom_range(0, 65535));
      else begin
        dv = cmd * 16 + int'($urandom_range(0, 600)) - 300;
        if (dv < 0) dv = 0;
      end
      offer(CH_W'($urandom_range(0, N_CH - 1)), ($urandom_range(0, 7) == 0),
            cmd, dv, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), acc);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    drain();
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
